// File: rtl/ddr.sv
// rtl/ddr.sv - DDR SDRAM power-up init and periodic auto-refresh sequencer
module ddr #(
    parameter int unsigned WAIT_CYCLES    = 26602,
    parameter int unsigned NOP_CYCLES     = 8,
    parameter int unsigned TRP_NOPS       = 2,
    parameter int unsigned TMRD_NOPS      = 1,
    parameter int unsigned TRFC_NOPS      = 10,
    parameter logic [12:0] MODE_REG       = 13'h021,
    parameter logic [12:0] EXT_MODE_REG   = 13'h000,
    parameter int unsigned REFRESH_CYCLES = 1024
) (
    input  logic        clk133_p,
    input  logic        rst,
    input  logic        clk133_n,
    input  logic        clk25,
    output logic [12:0] sd_A,
    output logic [1:0]  sd_BA,
    output logic        sd_RAS,
    output logic        sd_CAS,
    output logic        sd_WE,
    output logic        sd_CKE,
    output logic        sd_CS,
    output logic        sd_LDM,
    output logic        sd_UDM,
    inout  wire  [15:0] sd_DQ,
    inout  wire         sd_LDQS,
    inout  wire         sd_UDQS
);
    timeunit 1ns;
    timeprecision 1ps;

    typedef enum logic [3:0] {
        S_WAIT, S_CKE_NOP, S_PRE, S_LEMR, S_LMR1, S_PRE2,
        S_REF1, S_REF2, S_LMR2, S_IDLE, S_AREF
    } state_t;

    localparam logic [2:0] CMD_NOP  = 3'b111;
    localparam logic [2:0] CMD_PRE  = 3'b010;
    localparam logic [2:0] CMD_LOAD = 3'b000;
    localparam logic [2:0] CMD_REF  = 3'b001;

    localparam logic [14:0] WAIT_LAST = 15'(WAIT_CYCLES - 1);
    localparam logic [14:0] NOP_LAST  = 15'(NOP_CYCLES - 1);
    localparam logic [14:0] IDLE_LAST = 15'(REFRESH_CYCLES - 1);

    state_t      state_q = S_WAIT;
    logic [14:0] cnt_q   = '0;
    logic        cke_q   = 1'b0;
    logic [2:0]  cmd_q   = CMD_NOP;
    logic [12:0] a_q     = '0;
    logic [1:0]  ba_q    = '0;

    // Decode of the one-shot command states: command, trailing NOPs, successor
    logic [2:0]  st_cmd;
    logic [1:0]  st_ba;
    logic [12:0] st_a;
    logic [14:0] st_nops;
    state_t      st_next;

    always_comb begin
        st_cmd  = CMD_NOP;
        st_ba   = 2'b00;
        st_a    = '0;
        st_nops = '0;
        st_next = S_IDLE;
        case (state_q)
            S_PRE:  begin st_cmd = CMD_PRE;  st_a = 13'h400; st_nops = 15'(TRP_NOPS);  st_next = S_LEMR; end
            S_LEMR: begin st_cmd = CMD_LOAD; st_ba = 2'b01; st_a = EXT_MODE_REG;
                          st_nops = 15'(TMRD_NOPS); st_next = S_LMR1; end
            S_LMR1: begin st_cmd = CMD_LOAD; st_a = MODE_REG; st_nops = 15'(TMRD_NOPS); st_next = S_PRE2; end
            S_PRE2: begin st_cmd = CMD_PRE;  st_a = 13'h400; st_nops = 15'(TRP_NOPS);  st_next = S_REF1; end
            S_REF1: begin st_cmd = CMD_REF;  st_nops = 15'(TRFC_NOPS); st_next = S_REF2; end
            S_REF2: begin st_cmd = CMD_REF;  st_nops = 15'(TRFC_NOPS); st_next = S_LMR2; end
            S_LMR2: begin st_cmd = CMD_LOAD; st_a = MODE_REG; st_nops = 15'(TMRD_NOPS); st_next = S_IDLE; end
            S_AREF: begin st_cmd = CMD_REF;  st_nops = 15'(TRFC_NOPS); st_next = S_IDLE; end
            default: ;
        endcase
    end

    always_ff @(posedge clk133_p) begin
        if (rst) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            cke_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            a_q     <= '0;
            ba_q    <= '0;
        end else begin
            cmd_q <= CMD_NOP;
            a_q   <= '0;
            ba_q  <= '0;
            cke_q <= 1'b1;
            if (cnt_q != 15'h7fff) begin
                cnt_q <= cnt_q + 15'd1;
            end
            // A state change below overrides the increment, clearing the counter on entry
            case (state_q)
                S_WAIT: begin
                    cke_q <= 1'b0;
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= S_CKE_NOP;
                        cnt_q   <= '0;
                    end
                end
                S_CKE_NOP: begin
                    if (cnt_q == NOP_LAST) begin
                        state_q <= S_PRE;
                        cnt_q   <= '0;
                    end
                end
                S_IDLE: begin
                    if (cnt_q == IDLE_LAST) begin
                        state_q <= S_AREF;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        cmd_q <= st_cmd;
                        a_q   <= st_a;
                        ba_q  <= st_ba;
                    end
                    if (cnt_q == st_nops) begin
                        state_q <= st_next;
                        cnt_q   <= '0;
                    end
                end
            endcase
        end
    end

    assign sd_A    = a_q;
    assign sd_BA   = ba_q;
    assign sd_RAS  = cmd_q[2];
    assign sd_CAS  = cmd_q[1];
    assign sd_WE   = cmd_q[0];
    assign sd_CKE  = cke_q;
    assign sd_CS   = 1'b0;
    assign sd_LDM  = 1'b0;
    assign sd_UDM  = 1'b0;
    assign sd_DQ   = 16'bz;
    assign sd_LDQS = 1'bz;
    assign sd_UDQS = 1'bz;

    logic unused_pins;
    assign unused_pins = clk133_n ^ clk25;
endmodule

// File: tb/tb_ddr.sv
// tb/tb_ddr.sv - edge-accurate check of the DDR init and refresh command stream
module tb_ddr;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int WAITC = 26602;
    localparam int P     = 26611;
    localparam int R1    = P + 32 + 2 + 1024;
    localparam int R2    = R1 + 1 + 10 + 1024;
    localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, LOAD = 3'b000, REF = 3'b001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_n, clk25;
    logic [12:0] sd_A;
    logic [1:0]  sd_BA;
    logic sd_RAS, sd_CAS, sd_WE, sd_CKE, sd_CS, sd_LDM, sd_UDM;
    wire  [15:0] sd_DQ;
    wire  sd_LDQS, sd_UDQS;

    // The bench drives known levels onto the bidirectional pins; a released DUT leaves them intact
    assign sd_DQ   = 16'hA5C3;
    assign sd_LDQS = 1'b1;
    assign sd_UDQS = 1'b0;

    assign clk_n = ~clk;
    assign clk25 = 1'b0;

    always #3.759 clk = ~clk;

    ddr dut (
        .clk133_p(clk), .rst(rst), .clk133_n(clk_n), .clk25(clk25),
        .sd_A(sd_A), .sd_BA(sd_BA), .sd_RAS(sd_RAS), .sd_CAS(sd_CAS), .sd_WE(sd_WE),
        .sd_CKE(sd_CKE), .sd_CS(sd_CS), .sd_LDM(sd_LDM), .sd_UDM(sd_UDM),
        .sd_DQ(sd_DQ), .sd_LDQS(sd_LDQS), .sd_UDQS(sd_UDQS)
    );

    typedef struct {
        int         edge_n;
        logic [2:0] cmd;
        logic [1:0] ba;
        logic [12:0] a;
    } vec_t;

    typedef struct {
        int          edge_n;
        logic [21:0] word;
    } exp_t;

    vec_t specials[$];
    exp_t sb[$];
    int total = 0;
    int bad   = 0;
    int n     = 0;

    // {cs, ldm, udm, cke, cmd, ba, a}
    function automatic logic [21:0] pack(input logic cke, input logic [2:0] cmd,
                                         input logic [1:0] ba, input logic [12:0] a);
        return {3'b000, cke, cmd, ba, a};
    endfunction

    function automatic logic [21:0] observed();
        return {sd_CS, sd_LDM, sd_UDM, sd_CKE, sd_RAS, sd_CAS, sd_WE, sd_BA, sd_A};
    endfunction

    task automatic chk(input string nm, input int at, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%h want=%h", nm, at, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        n = rst ? 0 : n + 1;
        #1;
    endtask

    task automatic run_seq(input int last);
        int first_bad;
        logic [21:0] w;
        exp_t e;
        first_bad = 0;
        sb.delete();
        for (int ed = WAITC + 1; ed <= last; ed++) begin
            w = pack(1'b1, NOP, 2'b00, 13'h0);
            foreach (specials[k]) begin
                if (specials[k].edge_n == ed) w = pack(1'b1, specials[k].cmd, specials[k].ba, specials[k].a);
            end
            e.edge_n = ed;
            e.word   = w;
            sb.push_back(e);
        end
        while (n < last) begin
            step();
            if (n <= WAITC) begin
                if (observed() !== pack(1'b0, NOP, 2'b00, 13'h0) && first_bad == 0) first_bad = n;
                if (n == WAITC) chk("wait_quiet_first_bad_edge", n, first_bad, 0);
            end else if (sb.size() > 0 && sb[0].edge_n == n) begin
                e = sb.pop_front();
                chk("cmd_word", n, {10'h0, observed()}, {10'h0, e.word});
            end
        end
        chk("scoreboard_drained", n, sb.size(), 0);
    endtask

    initial begin
        vec_t v;
        v = '{P,      PRE,  2'b00, 13'h400}; specials.push_back(v);
        v = '{P + 3,  LOAD, 2'b01, 13'h000}; specials.push_back(v);
        v = '{P + 5,  LOAD, 2'b00, 13'h021}; specials.push_back(v);
        v = '{P + 7,  PRE,  2'b00, 13'h400}; specials.push_back(v);
        v = '{P + 10, REF,  2'b00, 13'h000}; specials.push_back(v);
        v = '{P + 21, REF,  2'b00, 13'h000}; specials.push_back(v);
        v = '{P + 32, LOAD, 2'b00, 13'h021}; specials.push_back(v);
        v = '{R1,     REF,  2'b00, 13'h000}; specials.push_back(v);
        v = '{R2,     REF,  2'b00, 13'h000}; specials.push_back(v);

        #5;
        chk("reset_cke", 0, sd_CKE, 0);
        chk("reset_word", 0, {10'h0, observed()}, {10'h0, pack(1'b0, NOP, 2'b00, 13'h0)});
        chk("dq_released", 0, sd_DQ, 32'hA5C3);
        chk("ldqs_released", 0, sd_LDQS, 1);
        chk("udqs_released", 0, sd_UDQS, 0);
        rst = 1'b0;

        run_seq(R2 + 6);
        chk("dq_released_idle", n, sd_DQ, 32'hA5C3);

        rst = 1'b1;
        step();
        chk("rst_pulse_word", n, {10'h0, observed()}, {10'h0, pack(1'b0, NOP, 2'b00, 13'h0)});
        rst = 1'b0;

        run_seq(P + 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
